// File: rtl/hamming_scrubber.sv
// Walks a stored word one 4-bit nibble per cycle, correcting single-bit errors in each
// Hamming(7,4) codeword in place and reporting per-class correction counts and the first faulty nibble.
module hamming_scrubber #(
  parameter int width       = 128,
  parameter int blocks      = width / 4,
  parameter int parity_bits = blocks * 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [width-1:0]             data_in,
  input  logic [parity_bits-1:0]       parity_in,
  output logic                         busy,
  output logic                         done,
  output logic [width-1:0]             data_out,
  output logic [parity_bits-1:0]       parity_out,
  output logic [$clog2(blocks+1)-1:0]  data_corr_cnt,
  output logic [$clog2(blocks+1)-1:0]  parity_corr_cnt,
  output logic [$clog2(blocks)-1:0]    first_err_idx,
  output logic                         err_flag
);

  localparam int CW = $clog2(blocks + 1);
  localparam int IW = $clog2(blocks);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [width-1:0]       data_q, data_d;
  logic [parity_bits-1:0] par_q, par_d;
  logic [CW-1:0]          dcnt_q, dcnt_d;
  logic [CW-1:0]          pcnt_q, pcnt_d;
  logic [IW-1:0]          first_q, first_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic [3:0] nib, nib_fix;
  logic [2:0] par, par_fix, syn;
  logic       is_data, is_par;

  // Syndrome and single-bit repair of the nibble currently addressed by idx_q.
  always_comb begin
    nib     = data_q[4*idx_q +: 4];
    par     = par_q[3*idx_q +: 3];
    syn     = {par[2] ^ nib[0] ^ nib[2] ^ nib[3],
               par[1] ^ nib[0] ^ nib[1] ^ nib[3],
               par[0] ^ nib[0] ^ nib[1] ^ nib[2]};
    nib_fix = nib;
    par_fix = par;
    is_data = 1'b0;
    is_par  = 1'b0;
    case (syn)
      3'b111: begin nib_fix[0] = ~nib[0]; is_data = 1'b1; end
      3'b011: begin nib_fix[1] = ~nib[1]; is_data = 1'b1; end
      3'b101: begin nib_fix[2] = ~nib[2]; is_data = 1'b1; end
      3'b110: begin nib_fix[3] = ~nib[3]; is_data = 1'b1; end
      3'b001: begin par_fix[0] = ~par[0]; is_par  = 1'b1; end
      3'b010: begin par_fix[1] = ~par[1]; is_par  = 1'b1; end
      3'b100: begin par_fix[2] = ~par[2]; is_par  = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    first_d = first_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          par_d   = parity_in;
          dcnt_d  = '0;
          pcnt_d  = '0;
          first_d = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        data_d[4*idx_q +: 4] = nib_fix;
        par_d[3*idx_q +: 3]  = par_fix;
        if (is_data) dcnt_d = dcnt_q + CW'(1);
        if (is_par)  pcnt_d = pcnt_q + CW'(1);
        if ((syn != 3'b000) && !err_q) begin
          err_d   = 1'b1;
          first_d = idx_q;
        end
        if (idx_q == IW'(blocks - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      first_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      first_q <= first_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign data_out        = data_q;
  assign parity_out      = par_q;
  assign data_corr_cnt   = dcnt_q;
  assign parity_corr_cnt = pcnt_q;
  assign first_err_idx   = first_q;
  assign err_flag        = err_q;

endmodule
